switch_debouncer: RTL and testbench

//   Conditions a raw, bouncing, asynchronous input (push-button/switch) into a clean

---
 rtl/switch_debouncer.sv | 138 +++++++++++++
 tb/tb_switch_debouncer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Debounces a bouncing asynchronous switch into a clean level with one-cycle rise/fall strobes.
// Latency: STABLE_CYCLES+2 clk edges from a settled raw_in to the db_out change and its strobe.
// Backpressure: none; free-running, every output is a registered level or strobe.
module switch_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_n,
    input  logic raw_in,
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic             sync1;
    logic             sync2;
    logic             sync_in;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             db_nxt;
    logic             rise_nxt;
    logic             fall_nxt;

    // Two-flop synchronizer; the clear also flushes it so requalification starts clean.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else if (!clear_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    assign sync_in = sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_LOW;
            cnt        <= CNT_ZERO;
            db_out     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else if (!clear_n) begin
            state      <= S_LOW;
            cnt        <= CNT_ZERO;
            db_out     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            db_out     <= db_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end

    // cnt holds how many consecutive samples have disagreed with db_out; it tops out at CNT_LAST.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        db_nxt    = db_out;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            S_LOW: begin
                if (sync_in) begin
                    state_nxt = S_WAIT_HIGH;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = CNT_ZERO;
                end
            end
            S_WAIT_HIGH: begin
                if (!sync_in) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = CNT_ZERO;
                    db_nxt    = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sync_in) begin
                    state_nxt = S_WAIT_LOW;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = CNT_ZERO;
                end
            end
            S_WAIT_LOW: begin
                if (sync_in) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = CNT_ZERO;
                    db_nxt    = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_LOW;
                cnt_nxt   = CNT_ZERO;
                db_nxt    = 1'b0;
            end
        endcase
    end

    assign busy = (state == S_WAIT_HIGH) || (state == S_WAIT_LOW);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed and randomized checks of switch_debouncer against a run-length reference model.
module tb_switch_debouncer;

    localparam int SC = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic clear_n;
    logic raw_in;
    logic db_out;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    int vectors     = 0;
    int miscompares = 0;

    // Reference: two-sample delay line, then db flips once SC consecutive samples disagree with it.
    bit m_s1, m_s2, m_db, m_rise, m_fall;
    int m_run;

    always #5 clk = ~clk;

    switch_debouncer #(.STABLE_CYCLES(SC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_n    (clear_n),
        .raw_in     (raw_in),
        .db_out     (db_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_rise = 0; m_fall = 0; m_run = 0;
    endtask

    task automatic model_edge(input logic raw, input logic clr);
        bit sample;
        sample = m_s2;
        m_rise = 0;
        m_fall = 0;
        if (!reset_n || !clr) begin
            model_reset();
        end else begin
            if (sample != m_db) begin
                m_run++;
                if (m_run == SC) begin
                    m_db   = sample;
                    m_rise = sample;
                    m_fall = !sample;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_db"},   db_out,     m_db);
        check({tag, "_rise"}, rise_pulse, m_rise);
        check({tag, "_fall"}, fall_pulse, m_fall);
        check({tag, "_busy"}, busy,       (m_run != 0));
    endtask

    task automatic step(input logic raw, input logic clr);
        raw_in  = raw;
        clear_n = clr;
        @(posedge clk);
        model_edge(raw, clr);
        #1;
    endtask

    initial begin
        logic lvl;
        logic clr;
        int   len;

        // Async reset with raw_in high, checked before any clock edge.
        reset_n = 1'b1;
        clear_n = 1'b1;
        raw_in  = 1'b1;
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_db",   db_out,     1'b0);
        check("rst_rise", rise_pulse, 1'b0);
        check("rst_fall", fall_pulse, 1'b0);
        check("rst_busy", busy,       1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check_model("rst_hold");
        #2 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            check_model("idle");
        end

        // Clean rise: db_out and strobe after E5, strobe gone after E6.
        for (int e = 0; e < 8; e++) begin
            step(1'b1, 1'b1);
            check("rise_db",    db_out,     (e >= 5));
            check("rise_pulse", rise_pulse, (e == 5));
            check_model("rise");
        end

        // Three-cycle low glitch while high: rejected.
        for (int e = 0; e < 10; e++) begin
            step((e < 3) ? 1'b0 : 1'b1, 1'b1);
            check("glitch_db",   db_out,     1'b1);
            check("glitch_fall", fall_pulse, 1'b0);
            check_model("glitch");
        end

        // Clean fall.
        for (int e = 0; e < 8; e++) begin
            step(1'b0, 1'b1);
            check("fall_db",    db_out,     (e < 5));
            check("fall_pulse", fall_pulse, (e == 5));
            check_model("fall");
        end

        // Bounce 1,1,0 then held 1: single rise 5 edges after the final 0->1 edge index.
        for (int e = 0; e < 12; e++) begin
            step((e == 2) ? 1'b0 : 1'b1, 1'b1);
            check("bounce_db",   db_out,     (e >= 8));
            check("bounce_rise", rise_pulse, (e == 8));
            check_model("bounce");
        end

        // Sync clear while high: silent drop, then requalify with raw_in still high.
        step(1'b1, 1'b0);
        check("clr_db",   db_out,     1'b0);
        check("clr_fall", fall_pulse, 1'b0);
        check("clr_busy", busy,       1'b0);
        for (int e = 0; e < 8; e++) begin
            step(1'b1, 1'b1);
            check("reclr_db",   db_out,     (e >= 5));
            check("reclr_rise", rise_pulse, (e == 5));
            check_model("reclr");
        end

        // Async reset mid-qualification (cnt == 2), then a full fresh qualification.
        for (int e = 0; e < 8; e++) begin
            step(1'b0, 1'b1);
        end
        check_model("pre_wait");
        for (int e = 0; e < 4; e++) begin
            step(1'b1, 1'b1);
        end
        check("wait_busy", busy, 1'b1);
        check("wait_cnt2", (dut.cnt == 2), 1'b1);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_cnt0", (dut.cnt == 0), 1'b1);
        check("midrst_db",   db_out, 1'b0);
        #1 reset_n = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step(1'b1, 1'b1);
            check("fresh_db",   db_out,     (e >= 5));
            check("fresh_rise", rise_pulse, (e == 5));
            check_model("fresh");
        end

        // Randomized bursts with occasional clears, against the reference model.
        for (int seg = 0; seg < 300; seg++) begin
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            clr = ($urandom_range(0, 39) != 0);
            for (int k = 0; k < len; k++) begin
                step(lvl, (k == 0) ? clr : 1'b1);
                check_model("rand");
                check("rand_excl", (rise_pulse && fall_pulse), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
